// File: rtl/spi_lcd_byte_feeder_pkg.sv
// Shared constants, state encoding and queue entry layout for the LCD byte feeder.
package spi_lcd_byte_feeder_pkg;

  localparam int unsigned ENTRY_W = 9;
  localparam logic        DC_CMD  = 1'b0;
  localparam logic        DC_DATA = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } entry_t;

endpackage

// File: rtl/spi_lcd_byte_feeder_fifo.sv
// Circular-buffer FIFO with registered full/empty flags and an occupancy count.
module sync_fifo_tagged #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CW-1:0]    next_count;

  // Pushes into a full queue and pops from an empty one are both dropped.
  always_comb begin
    do_push    = push && !full;
    do_pop     = pop && !empty;
    next_count = count + CW'(do_push) - CW'(do_pop);
  end

  assign dout = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= next_count;
      full  <= (next_count == CW'(DEPTH));
      empty <= (next_count == '0);
    end
  end

endmodule

// File: rtl/spi_lcd_byte_feeder.sv
// Queues tagged LCD bytes and drives the byte-level SPI transmitter's cs/data and the D/C pin.
module spi_lcd_byte_feeder
  import spi_lcd_byte_feeder_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CS_GAP = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic       wr_dc,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       overflow,
  output logic       tx_cs,
  output logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       lcd_dc,
  output logic       byte_done
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_t        state;
  logic [7:0]    gap_cnt;
  entry_t        head;
  entry_t        wr_entry;
  logic [CW-1:0] fifo_count;
  logic          has_data_c;
  logic          pop_c;

  assign wr_entry = '{dc: wr_dc, data: wr_data};

  sync_fifo_tagged #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_en),
    .pop   (pop_c),
    .din   (wr_entry),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // Head is consumed on the IDLE launch, or on a same-kind continuation inside a burst.
  always_comb begin
    has_data_c = (fifo_count != '0);
    pop_c      = 1'b0;
    unique case (state)
      IDLE:    pop_c = has_data_c;
      SEND:    pop_c = tx_valid && has_data_c && (head.dc == lcd_dc);
      default: pop_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      gap_cnt   <= '0;
      tx_cs     <= 1'b1;
      tx_data   <= '0;
      lcd_dc    <= DC_CMD;
      byte_done <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      byte_done <= (state == SEND) && tx_valid;
      if (wr_en && full) overflow <= 1'b1;

      unique case (state)
        // D/C only changes here, while cs is still high.
        IDLE: begin
          tx_cs <= 1'b1;
          if (has_data_c) begin
            tx_data <= head.data;
            lcd_dc  <= head.dc;
            tx_cs   <= 1'b0;
            busy    <= 1'b1;
            state   <= SEND;
          end
        end
        SEND: begin
          if (tx_valid) begin
            if (pop_c) begin
              tx_data <= head.data;
            end else begin
              tx_cs   <= 1'b1;
              gap_cnt <= 8'(CS_GAP);
              state   <= GAP;
            end
          end
        end
        // Counter reaches zero on the same edge the state returns to IDLE.
        GAP: begin
          tx_cs   <= 1'b1;
          gap_cnt <= gap_cnt - 8'd1;
          if (gap_cnt <= 8'd1) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          tx_cs <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
